alu_stage: RTL and testbench

//  Datapath stage directly downstream of the D0 operand register: consumes the D0 operand (A) and the D1 operand (B),

---
 rtl/cpu_defs.sv | 47 ++++
 rtl/alu_mul_seq.sv | 77 +++++++
 rtl/alu_stage.sv | 124 ++++++++++++
 tb/tb_alu_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared control-word layout, ALU opcodes and flag positions for the datapath stages
// and the control sequencer.
package cpu_defs;

    localparam int ALU_OP_MSB = 15;
    localparam int ALU_OP_LSB = 12;
    localparam int ALU_START  = 11;
    localparam int ALU_OE     = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    // Encodings 4'hC..4'hF are reserved and act as NOPs.
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_INC  = 4'h8,
        OP_DEC  = 4'h9,
        OP_MUL  = 4'hA,
        OP_PASS = 4'hB
    } alu_op_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

    function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                              input logic c, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per cycle, full 2*WIDTH product.
// o_done pulses on the final iteration with o_product already valid.
module alu_mul_seq
    import cpu_defs::*;
#(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int            CW   = $clog2(MUL_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    mul_state_e           r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_product = w_acc_nxt;
    assign o_busy    = (r_state == MUL_RUN);

    always_comb begin
        w_state_nxt = r_state;
        o_done      = 1'b0;
        case (r_state)
            MUL_IDLE: if (i_start) w_state_nxt = MUL_RUN;
            MUL_RUN: begin
                if (r_cnt == LAST) begin
                    o_done      = 1'b1;
                    w_state_nxt = MUL_IDLE;
                end
            end
            default: w_state_nxt = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= MUL_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, i_a};
                        r_mplier <= i_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                MUL_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= o_done ? '0 : r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_stage.sv
// ALU datapath stage: decodes the control word, runs single-cycle ops or the MUL
// sequencer, registers result/flags and drives the result onto the shared bus.
module alu_stage
    import cpu_defs::*;
#(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      ControlSignals,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    inout  wire  [WIDTH-1:0] DataBus,
    output logic [3:0]       Flags,
    output logic             Busy
);

    localparam int M = WIDTH - 1;

    logic [3:0]         w_op;
    logic               w_start;
    logic               w_oe;
    logic               w_busy;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic               w_unused;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_valid;
    logic               w_sc_fire;

    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    assign w_op     = ControlSignals[ALU_OP_MSB:ALU_OP_LSB];
    assign w_start  = ControlSignals[ALU_START];
    assign w_oe     = ControlSignals[ALU_OE];
    assign w_unused = ^{ControlSignals[10:5], ControlSignals[3:0]};

    // Starts seen while the multiplier runs are dropped, not queued.
    assign w_mul_start = w_start & ~w_busy & (w_op == OP_MUL);
    assign w_sc_fire   = w_start & ~w_busy & w_valid;

    alu_mul_seq #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_a       (OperandA),
        .i_b       (OperandB),
        .o_busy    (w_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // Carry on SUB/DEC is the borrow, taken from the (WIDTH+1)-bit difference.
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_valid = 1'b1;
        case (w_op)
            OP_ADD: begin
                w_sum = {1'b0, OperandA} + {1'b0, OperandB};
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = (OperandA[M] == OperandB[M]) && (w_res[M] != OperandA[M]);
            end
            OP_SUB: begin
                w_sum = {1'b0, OperandA} - {1'b0, OperandB};
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = (OperandA[M] != OperandB[M]) && (w_res[M] != OperandA[M]);
            end
            OP_INC: begin
                w_sum = {1'b0, OperandA} + (WIDTH+1)'(1);
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = ~OperandA[M] & w_res[M];
            end
            OP_DEC: begin
                w_sum = {1'b0, OperandA} - (WIDTH+1)'(1);
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = OperandA[M] & ~w_res[M];
            end
            OP_AND:  w_res = OperandA & OperandB;
            OP_OR:   w_res = OperandA | OperandB;
            OP_XOR:  w_res = OperandA ^ OperandB;
            OP_NOT:  w_res = ~OperandA;
            OP_SHL:  {w_c, w_res} = {OperandA, 1'b0};
            OP_SHR:  {w_res, w_c} = {1'b0, OperandA};
            OP_PASS: w_res = OperandA;
            default: w_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_mul_done) begin
            r_result <= w_product[M:0];
            r_flags  <= pack_flags(1'b0, w_product[M], |w_product[2*WIDTH-1:WIDTH],
                                   w_product[M:0] == '0);
        end else if (w_sc_fire) begin
            r_result <= w_res;
            r_flags  <= pack_flags(w_v, w_res[M], w_c, w_res == '0);
        end
    end

    assign DataBus = w_oe ? r_result : 'z;
    assign Flags   = r_flags;
    assign Busy    = w_busy;

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: one task per scenario, inline checks against
// hand-computed results.
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cs;
    logic [7:0]  opa, opb;
    wire  [7:0]  DataBus;
    logic [3:0]  Flags;
    logic        Busy;
    logic        drv_en;
    logic [7:0]  drv_val;

    int pass_cnt = 0;
    int total    = 0;

    assign DataBus = drv_en ? drv_val : 'z;

    always #5 clk = ~clk;

    alu_stage #(.WIDTH(8), .MUL_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .ControlSignals (cs),
        .OperandA       (opa),
        .OperandB       (opb),
        .DataBus        (DataBus),
        .Flags          (Flags),
        .Busy           (Busy)
    );

    // Present an op with start for one edge, keeping OE on; sample point is #1 after the edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        cs  = {op, 1'b1, 6'b0, 1'b1, 4'b0};
        opa = a;
        opb = b;
        @(posedge clk);
        #1;
        cs[11] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cs = 16'h0010; opa = '0; opb = '0; drv_en = 1'b0; drv_val = '0;
        #12;
        total++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else pass_cnt++;
        total++; if (Flags !== 4'h0) $display("FAIL reset_flags: got %h want 0", Flags); else pass_cnt++;
        total++; if (DataBus !== 8'h00) $display("FAIL reset_result: got %h want 00", DataBus); else pass_cnt++;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_add();
        issue(4'h0, 8'h7F, 8'h01);
        total++; if (DataBus !== 8'h80) $display("FAIL add_result: got %h want 80", DataBus); else pass_cnt++;
        total++; if (Flags !== 4'b1100) $display("FAIL add_flags: got %b want 1100", Flags); else pass_cnt++;
    endtask

    task automatic test_arith_edges();
        logic [3:0] ops  [8] = '{4'h1, 4'h8, 4'h7, 4'h9, 4'h6, 4'h4, 4'h5, 4'hB};
        logic [7:0] as   [8] = '{8'h00, 8'hFF, 8'h01, 8'h00, 8'h81, 8'hF0, 8'h00, 8'h00};
        logic [7:0] bs   [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic [7:0] exr  [8] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h02, 8'h0F, 8'hFF, 8'h00};
        logic [3:0] exf  [8] = '{4'b0110, 4'b0011, 4'b0011, 4'b0110, 4'b0010, 4'b0000, 4'b0100, 4'b0001};
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            total++;
            if (DataBus !== exr[i]) $display("FAIL op%h_result: got %h want %h", ops[i], DataBus, exr[i]);
            else pass_cnt++;
            total++;
            if (Flags !== exf[i]) $display("FAIL op%h_flags: got %b want %b", ops[i], Flags, exf[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mul();
        int cnt;
        issue(4'hA, 8'h0C, 8'h0B);
        opa = 8'hFF; opb = 8'hFF;   // captured copies must be used
        cnt = 0;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            @(posedge clk); #1;
        end
        total++; if (cnt !== 8) $display("FAIL mul_busy_cycles: got %0d want 8", cnt); else pass_cnt++;
        total++; if (DataBus !== 8'h84) $display("FAIL mul_result: got %h want 84", DataBus); else pass_cnt++;
        total++; if (Flags !== 4'b0100) $display("FAIL mul_flags: got %b want 0100", Flags); else pass_cnt++;

        issue(4'hA, 8'h10, 8'h10);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            @(posedge clk); #1;
        end
        total++; if (cnt !== 8) $display("FAIL mul2_busy_cycles: got %0d want 8", cnt); else pass_cnt++;
        total++; if (DataBus !== 8'h00) $display("FAIL mul2_result: got %h want 00", DataBus); else pass_cnt++;
        total++; if (Flags !== 4'b0011) $display("FAIL mul2_flags: got %b want 0011", Flags); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int cnt;
        issue(4'hB, 8'h5A, 8'h00);
        issue(4'hA, 8'h03, 8'h05);
        @(posedge clk); #1;
        issue(4'h0, 8'h11, 8'h22);
        total++; if (Busy !== 1'b1) $display("FAIL busy_during_mul: got %b want 1", Busy); else pass_cnt++;
        total++; if (DataBus !== 8'h5A) $display("FAIL bus_during_mul: got %h want 5A", DataBus); else pass_cnt++;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            @(posedge clk); #1;
        end
        total++; if (cnt >= 20) $display("FAIL busy_timeout: got %0d cycles want <20", cnt); else pass_cnt++;
        total++; if (DataBus !== 8'h0F) $display("FAIL mul_after_ignore: got %h want 0F", DataBus); else pass_cnt++;
        total++; if (Flags !== 4'b0000) $display("FAIL mul_after_ignore_flags: got %b want 0000", Flags); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        issue(4'hB, 8'h80, 8'h00);
        issue(4'hA, 8'h0C, 8'h0B);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++; if (Busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", Busy); else pass_cnt++;
        total++; if (Flags !== 4'h0) $display("FAIL arst_flags: got %b want 0000", Flags); else pass_cnt++;
        total++; if (DataBus !== 8'h00) $display("FAIL arst_result: got %h want 00", DataBus); else pass_cnt++;
        @(negedge clk); reset = 1'b1;
        issue(4'h0, 8'h02, 8'h03);
        total++; if (DataBus !== 8'h05) $display("FAIL post_rst_add: got %h want 05", DataBus); else pass_cnt++;
        total++; if (Flags !== 4'b0000) $display("FAIL post_rst_flags: got %b want 0000", Flags); else pass_cnt++;
        repeat (10) @(posedge clk);
        #1;
        total++; if (DataBus !== 8'h05) $display("FAIL aborted_mul_write: got %h want 05", DataBus); else pass_cnt++;
    endtask

    task automatic test_oe_nop();
        issue(4'h1, 8'h00, 8'h01);
        @(negedge clk);
        cs = 16'h0000; drv_val = 8'hA5; drv_en = 1'b1;
        #1;
        total++; if (DataBus !== 8'hA5) $display("FAIL bus_hiz_ext: got %h want A5", DataBus); else pass_cnt++;
        drv_en = 1'b0;
        issue(4'hF, 8'h33, 8'h44);
        total++; if (DataBus !== 8'hFF) $display("FAIL nop_result: got %h want FF", DataBus); else pass_cnt++;
        total++; if (Flags !== 4'b0110) $display("FAIL nop_flags: got %b want 0110", Flags); else pass_cnt++;
        total++; if (Busy !== 1'b0) $display("FAIL nop_busy: got %b want 0", Busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_arith_edges();
        test_mul();
        test_busy_ignore();
        test_async_reset();
        test_oe_nop();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
